// File: rtl/italos_pkg.sv
// Shared constants and types for the iTalos arm pose path.
// PS/2 scan codes, pose widths and sequencer states.
package italos_pkg;

  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [3:0] W_F = 4'd4;
  localparam logic [3:0] W_Q = 4'd5;
  localparam logic [3:0] W_H = 4'd6;
  localparam logic [3:0] W_X = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    SLEW,
    HOLD
  } seq_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] width;
  } pose_t;

  function automatic pose_t decode_pose(
    input logic [7:0] code
  );
    pose_t p;
    unique case (1'b1)
      (code == SC_F): p = '{1'b1, W_F};
      (code == SC_Q): p = '{1'b1, W_Q};
      (code == SC_H): p = '{1'b1, W_H};
      (code == SC_X): p = '{1'b1, W_X};
      default:        p = '{1'b0, 4'd0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pose_fifo.sv
// Small synchronous FIFO of pose widths.
// Count-based full/empty; a pop frees room for a same-cycle push.
module pose_fifo
  import italos_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         Pixelclock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge Pixelclock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/servo_pose_sequencer.sv
// Pose command scheduler for the single-servo iTalos arm.
// PS/2 keys queue poses; the servo slews one tick per PWM frame.
module servo_pose_sequencer
  import italos_pkg::*;
#(
  parameter int         DIV         = 6250,
  parameter int         FRAME_TICKS = 81,
  parameter int         QDEPTH      = 4,
  parameter int         HOLD_FRAMES = 25,
  parameter logic [3:0] W_RESET     = 4'd4
) (
  input  logic       Pixelclock,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       Servo_PWM,
  output logic [3:0] cur_width,
  output logic       busy,
  output logic       q_full,
  output logic       q_overflow
);

  localparam int PW = $clog2(DIV);
  localparam int FW = $clog2(FRAME_TICKS);
  localparam int HW =
    (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [FW-1:0] FR_LAST   = FW'(FRAME_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  logic [PW-1:0] presc;
  logic [FW-1:0] frame_cnt;
  logic          tick;
  logic          frame_end;

  assign tick      = (presc == PRE_LAST);
  assign frame_end = tick & (frame_cnt == FR_LAST);

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      frame_cnt <= '0;
      Servo_PWM <= 1'b0;
    end else begin
      presc     <= tick ? '0 : presc + 1'b1;
      Servo_PWM <= (frame_cnt < FW'(cur_width));
      if (tick)
        frame_cnt <= (frame_cnt == FR_LAST) ?
                     '0 : frame_cnt + 1'b1;
    end
  end

  pose_t      pose;
  logic       brk;
  logic       push;
  logic       pop;
  logic       q_empty;
  logic [3:0] q_head;
  seq_state_t state;

  assign pose = decode_pose(key_code);
  assign push = key_valid & ~brk & pose.hit;
  assign pop  = frame_end & (state == IDLE) & ~q_empty;

  // A break prefix swallows exactly the next byte, whatever it is.
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      brk        <= 1'b0;
      q_overflow <= 1'b0;
    end else begin
      if (key_valid) begin
        if (key_code == SC_BREAK) brk <= 1'b1;
        else if (brk)             brk <= 1'b0;
      end
      if (push & q_full & ~pop) q_overflow <= 1'b1;
    end
  end

  pose_fifo #(
    .DEPTH (QDEPTH),
    .W     (4)
  ) u_fifo (
    .Pixelclock (Pixelclock),
    .reset      (reset),
    .push       (push),
    .din        (pose.width),
    .pop        (pop),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty)
  );

  logic [3:0]    target;
  logic [3:0]    next_w;
  logic [HW-1:0] hold_cnt;

  assign next_w = (cur_width < target) ?
                  cur_width + 4'd1 : cur_width - 4'd1;

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cur_width <= W_RESET;
      target    <= W_RESET;
      hold_cnt  <= '0;
    end else if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (!q_empty) begin
            target   <= q_head;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= (q_head == cur_width) ? HOLD : SLEW;
          end
        end
        SLEW: begin
          cur_width <= next_w;
          if (next_w == target) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pose_sequencer.sv
// Randomised bench for servo_pose_sequencer.
// A frame-level pose model predicts every output each cycle.
module tb_servo_pose_sequencer;

  localparam int DIV   = 4;
  localparam int FT    = 81;
  localparam int QD    = 4;
  localparam int HF    = 2;
  localparam int WR    = 4;
  localparam int FRAME = DIV * FT;

  logic       Pixelclock = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] key_code   = 8'h00;
  logic       key_valid  = 1'b0;
  logic       Servo_PWM;
  logic [3:0] cur_width;
  logic       busy;
  logic       q_full;
  logic       q_overflow;

  int total = 0;
  int bad   = 0;

  int k;
  int m_cur;
  int m_tgt;
  int m_hold;
  bit m_active;
  bit m_brk;
  bit m_ovf;
  bit m_pwm;
  int mq[$];

  int falls[$];
  int fall_k[$];
  int steps[$];
  int step_k[$];

  servo_pose_sequencer #(
    .DIV         (DIV),
    .FRAME_TICKS (FT),
    .QDEPTH      (QD),
    .HOLD_FRAMES (HF),
    .W_RESET     (4'(WR))
  ) dut (
    .Pixelclock (Pixelclock),
    .reset      (reset),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .Servo_PWM  (Servo_PWM),
    .cur_width  (cur_width),
    .busy       (busy),
    .q_full     (q_full),
    .q_overflow (q_overflow)
  );

  always #5 Pixelclock = ~Pixelclock;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pose_of(input logic [7:0] c);
    case (c)
      8'h2B:   return 4;
      8'h15:   return 5;
      8'h33:   return 6;
      8'h22:   return 8;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    k        = 0;
    m_cur    = WR;
    m_tgt    = WR;
    m_hold   = 0;
    m_active = 0;
    m_brk    = 0;
    m_ovf    = 0;
    m_pwm    = 0;
    mq.delete();
  endtask

  // One clock edge of the arm: pose work happens once per frame.
  task automatic model_step();
    int ph;
    int w;
    ph    = k % FRAME;
    m_pwm = ((ph / DIV) < m_cur);
    if (ph == FRAME - 1) begin
      if (!m_active) begin
        if (mq.size() > 0) begin
          m_tgt    = mq.pop_front();
          m_active = 1;
          m_hold   = (m_tgt == m_cur) ? HF : 0;
        end
      end else if (m_cur != m_tgt) begin
        m_cur = m_cur + ((m_cur < m_tgt) ? 1 : -1);
        if (m_cur == m_tgt) m_hold = HF;
      end else begin
        m_hold--;
        if (m_hold == 0) m_active = 0;
      end
    end
    if (key_valid) begin
      w = pose_of(key_code);
      if (key_code == 8'hF0) m_brk = 1;
      else if (m_brk) m_brk = 0;
      else if (w != 0) begin
        if (mq.size() < QD) mq.push_back(w);
        else m_ovf = 1;
      end
    end
    k++;
  endtask

  task automatic check_outputs();
    check("pwm",   Servo_PWM,  m_pwm);
    check("width", cur_width,  m_cur);
    check("busy",  busy,       m_active);
    check("full",  q_full,     mq.size() == QD);
    check("ovf",   q_overflow, m_ovf);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_pwm"},   Servo_PWM,  0);
    check({p, "_width"}, cur_width,  WR);
    check({p, "_busy"},  busy,       0);
    check({p, "_full"},  q_full,     0);
    check({p, "_ovf"},   q_overflow, 0);
  endtask

  task automatic cyc();
    @(posedge Pixelclock);
    model_step();
    @(negedge Pixelclock);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] c);
    key_code  = c;
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Pixelclock);
    #2 reset = 1'b1;
    @(negedge Pixelclock);
    @(negedge Pixelclock);
    check_reset_vals("rst");
    model_reset();
    reset = 1'b0;
  endtask

  task automatic wait_active(input int limit);
    int t;
    t = 0;
    while (!m_active && t < limit) begin
      cyc();
      t++;
    end
    check("wait_active", m_active, 1);
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while ((m_active || mq.size() > 0) && t < limit) begin
      cyc();
      t++;
    end
    check("wait_idle", m_active || mq.size() > 0, 0);
  endtask

  task automatic collect(input int n, input int limit);
    logic       pb;
    logic [3:0] pw;
    int         t;
    falls.delete();
    fall_k.delete();
    steps.delete();
    step_k.delete();
    pb = busy;
    pw = cur_width;
    t  = 0;
    while (falls.size() < n && t < limit) begin
      cyc();
      t++;
      if (cur_width != pw) begin
        steps.push_back(int'(cur_width));
        step_k.push_back(k);
      end
      if (pb && !busy) begin
        falls.push_back(int'(cur_width));
        fall_k.push_back(k);
      end
      pb = busy;
      pw = cur_width;
    end
    check("collect_timeout", falls.size(), n);
  endtask

  task automatic pulse_window(input string tag);
    int hi;
    hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      if (Servo_PWM) hi++;
    end
    check(tag, hi, WR * DIV);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(7))
      0:       return 8'h2B;
      1:       return 8'h15;
      2:       return 8'h33;
      3:       return 8'h22;
      4:       return 8'hF0;
      5:       return 8'hE0;
      6:       return 8'($urandom_range(255));
      default: return 8'h22;
    endcase
  endfunction

  initial begin
    int ex_steps[4];
    int ex_burst[5];
    int ex_fp[5];
    int t;
    ex_steps = '{5, 6, 7, 8};
    ex_burst = '{4, 4, 5, 6, 8};
    ex_fp    = '{5, 6, 4, 8, 5};

    repeat (2) @(negedge Pixelclock);
    check_reset_vals("init");
    model_reset();
    reset = 1'b0;

    pulse_window("idle_pulse0");
    pulse_window("idle_pulse1");

    send(8'h22);
    collect(1, 10 * FRAME);
    check("x_nsteps", steps.size(), 4);
    for (int i = 0; i < 4 && i < steps.size(); i++)
      check("x_step", steps[i], ex_steps[i]);
    for (int i = 1; i < step_k.size(); i++)
      check("x_step_gap", step_k[i] - step_k[i-1], FRAME);
    if (step_k.size() > 0 && fall_k.size() > 0)
      check("x_hold_len",
            fall_k[0] - step_k[step_k.size()-1], HF * FRAME);

    send(8'h2B);
    wait_active(2 * FRAME);
    send(8'h2B);
    send(8'h15);
    send(8'h33);
    send(8'h22);
    check("b_full4", q_full, 1);
    check("b_ovf4", q_overflow, 0);
    send(8'h2B);
    check("b_ovf5", q_overflow, 1);
    send(8'h15);
    check("b_full6", q_full, 1);
    collect(5, 60 * FRAME);
    for (int i = 0; i < 5 && i < falls.size(); i++)
      check("b_order", falls[i], ex_burst[i]);

    send(8'hF0);
    send(8'h22);
    send(8'h33);
    send(8'hE0);
    send(8'h2B);
    collect(2, 30 * FRAME);
    if (falls.size() == 2) begin
      check("brk_first", falls[0], 6);
      check("ext_second", falls[1], 4);
    end

    do_reset();
    send(8'h22);
    wait_active(2 * FRAME);
    send(8'h15);
    send(8'h33);
    send(8'h2B);
    send(8'h22);
    t = 0;
    while (!(!m_active && mq.size() == QD &&
             (k % FRAME) == FRAME - 1) && t < 20 * FRAME) begin
      cyc();
      t++;
    end
    check("fp_reach", t < 20 * FRAME, 1);
    send(8'h15);
    check("fp_full", q_full, 1);
    check("fp_ovf", q_overflow, 0);
    check("fp_busy", busy, 1);
    collect(5, 60 * FRAME);
    for (int i = 0; i < 5 && i < falls.size(); i++)
      check("fp_order", falls[i], ex_fp[i]);

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(149) == 0) send(pick());
      else cyc();
    end
    wait_idle(60 * FRAME);

    do_reset();
    send(8'h22);
    send(8'h33);
    t = 0;
    while (!(m_cur == 6 && m_pwm) && t < 10 * FRAME) begin
      cyc();
      t++;
    end
    check("ms_reach", cur_width, 6);
    check("ms_pwm_hi", Servo_PWM, 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("ms");
    model_reset();
    @(negedge Pixelclock);
    @(negedge Pixelclock);
    reset = 1'b0;
    pulse_window("ms_pulse0");
    pulse_window("ms_pulse1");
    check("ms_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
